// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: request/response structs, FSM states, counter width.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package dmem_ctrl_pkg;

    // Width of the response-latency down-counter. The latency_p values it can hold are 1..15.
    localparam int dmem_lat_width_gp = 4;

    typedef logic [dmem_lat_width_gp-1:0] dmem_cnt_t;

    // Request from the core's load/store path.
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;          // requester consumes the pending response
    } mem_in_s;

    // Response back to the core.
    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;          // controller accepts the offered request
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE_D,
        BUSY_D,
        RESP_D
    } dmem_state_e;

    // Select one byte lane of a 32-bit word (lane 0 = bits 7:0).
    function automatic logic [7:0] dmem_pick_byte(input logic [31:0] word,
                                                  input logic [1:0]  lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port-style storage array: 2^addr_width_p x 32 bits, byte-lane write enables, registered read port.
// Latency: write commits on the clock edge; read data appears the cycle after rd_en.
// Backpressure: none; rd_data holds its value until the next rd_en.
//
// Ports:
//   clk              clock
//   wr_be[3:0]       per-byte write enable (all zero = no write)
//   wr_addr/wr_data  write word index and data
//   rd_en/rd_addr    read strobe and word index
//   rd_data          registered read data
module dmem_bank
    import dmem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic [3:0]              wr_be,
    input  logic [addr_width_p-1:0] wr_addr,
    input  logic [31:0]             wr_data,
    input  logic                    rd_en,
    input  logic [addr_width_p-1:0] rd_addr,
    output logic [31:0]             rd_data
);

    localparam int depth_lp = 1 << addr_width_p;

    // Contents are deliberately not reset; the read register is not reset either,
    // the controller gates it off the response bus outside a load response.
    logic [31:0] mem [depth_lp];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding load/store, word or byte, behind a valid/yumi handshake.
// Latency: response valid latency_p cycles after the accepting cycle (latency_p in 1..15).
// Backpressure: requests only accepted in IDLE; the response is held stable until mem_i.yumi.
//
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous, active-low
//   mem_i    request (write_data, valid, wen, byte_not_word) and response consume (yumi)
//   addr_i   byte address; word index addr_i[2 +: addr_width_p], byte lane addr_i[1:0]
//   mem_o    response (read_data, valid) and request accept (yumi)
//
// Build option: define DMEM_BYTE_OPS_EN to enable byte loads/stores. Without it
// byte_not_word is ignored and every access is a full-word access.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    mem_o
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    generate
        if (latency_p < 1 || latency_p > 15) begin : g_bad_latency
            $error("dmem_ctrl: latency_p must be in 1..15");
        end
    endgenerate

    localparam dmem_cnt_t lat_load_lp   = dmem_cnt_t'(latency_p - 1);
    localparam bit        direct_resp_lp = (latency_p == 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    dmem_state_e             state_q, state_d;
    dmem_cnt_t               cnt_q, cnt_d;

    logic [addr_width_p-1:0] widx_q;
    logic [31:0]             wdata_q;
    logic                    wen_q;
`ifdef DMEM_BYTE_OPS_EN
    logic [1:0]              lane_q;
    logic                    bnw_q;
`endif

    logic                    accept;
    logic                    commit;
    logic [addr_width_p-1:0] widx_live;

    assign widx_live = addr_i[2 +: addr_width_p];

    // Reset gates the accept so nothing is taken while reset is held.
    assign accept = reset && (state_q == IDLE_D) && mem_i.valid;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE_D;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter is loaded with latency_p-1 on accept and counts down in BUSY;
    // the commit happens on the edge where it reaches zero (i.e. while it reads 1),
    // which puts the response exactly latency_p cycles after the accept.
    // With latency_p==1 the commit is on the accepting edge itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE_D: begin
                if (accept) begin
                    cnt_d = lat_load_lp;
                    if (direct_resp_lp) begin
                        state_d = RESP_D;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY_D;
                    end
                end
            end
            BUSY_D: begin
                cnt_d = cnt_q - dmem_cnt_t'(1);
                if (cnt_q == dmem_cnt_t'(1)) begin
                    state_d = RESP_D;
                    commit  = 1'b1;
                end
            end
            RESP_D: begin
                if (mem_i.yumi) begin
                    state_d = IDLE_D;
                end
            end
            default: begin
                state_d = IDLE_D;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latches and counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            widx_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
`ifdef DMEM_BYTE_OPS_EN
            lane_q  <= 2'd0;
            bnw_q   <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                widx_q  <= widx_live;
                wdata_q <= mem_i.write_data;
                wen_q   <= mem_i.wen;
`ifdef DMEM_BYTE_OPS_EN
                lane_q  <= addr_i[1:0];
                bnw_q   <= mem_i.byte_not_word;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    // A commit seen in IDLE can only be the latency_p==1 case, where the
    // request fields are still on the inputs and not yet in the latches.
    logic [addr_width_p-1:0] wr_idx;
    logic [31:0]             wr_src;
    logic                    wr_wen;
    logic [3:0]              wr_be;
    logic [31:0]             wr_data;
`ifdef DMEM_BYTE_OPS_EN
    logic [1:0]              wr_lane;
    logic                    wr_bnw;
`endif

    always_comb begin
        if (state_q == IDLE_D) begin
            wr_idx  = widx_live;
            wr_src  = mem_i.write_data;
            wr_wen  = mem_i.wen;
        end else begin
            wr_idx  = widx_q;
            wr_src  = wdata_q;
            wr_wen  = wen_q;
        end
    end

`ifdef DMEM_BYTE_OPS_EN
    always_comb begin
        if (state_q == IDLE_D) begin
            wr_lane = addr_i[1:0];
            wr_bnw  = mem_i.byte_not_word;
        end else begin
            wr_lane = lane_q;
            wr_bnw  = bnw_q;
        end
    end
`endif

    always_comb begin
        wr_be   = 4'h0;
        wr_data = wr_src;
        if (commit && wr_wen) begin
`ifdef DMEM_BYTE_OPS_EN
            if (wr_bnw) begin
                // Replicate the byte so whichever lane is enabled sees it.
                wr_be   = 4'b0001 << wr_lane;
                wr_data = {4{wr_src[7:0]}};
            end else begin
                wr_be   = 4'hF;
            end
`else
            wr_be = 4'hF;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // The read is issued on the accepting edge. The bank's read register then
    // holds the word unchanged until the next accept, so it doubles as the
    // response data holding register for the whole BUSY/RESP period. Only one
    // request is ever outstanding, so no store can slip in between.
    logic [31:0] bank_rdata;

    dmem_bank #(
        .addr_width_p (addr_width_p)
    ) u_bank (
        .clk     (clk),
        .wr_be   (wr_be),
        .wr_addr (wr_idx),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_addr (widx_live),
        .rd_data (bank_rdata)
    );

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    logic [31:0] load_data;

    always_comb begin
        load_data = bank_rdata;
`ifdef DMEM_BYTE_OPS_EN
        if (bnw_q) begin
            load_data = {24'h0, dmem_pick_byte(bank_rdata, lane_q)};
        end
`endif
    end

    // read_data is forced to zero outside a load response, which also gives
    // the zero value during reset and for store responses.
    always_comb begin
        mem_o       = '0;
        mem_o.yumi  = accept;
        mem_o.valid = (state_q == RESP_D);
        if ((state_q == RESP_D) && !wen_q) begin
            mem_o.read_data = load_data;
        end
    end

    // Address bits above the array and, in the word-only build, the lane bits
    // and byte_not_word are intentionally ignored.
    logic unused_inputs;
`ifdef DMEM_BYTE_OPS_EN
    assign unused_inputs = ^addr_i[31:2+addr_width_p];
`else
    assign unused_inputs = ^{addr_i[31:2+addr_width_p], addr_i[1:0], mem_i.byte_not_word};
`endif

endmodule
